led_pwm_blink_driver: RTL
=========================

Name: led_pwm_blink_driver

Overview:
- Downstream stage of the HPS LED output PIO: consumes its 4-bit pattern word and drives the physical LED pins.
- Adds per-LED 8-bit PWM brightness and per-LED blink gating.
- Configured through its own small Avalon-MM slave with 0 read wait states and combinational readdata.
- Sits between the PIO out_port and the top-level LED pins.

Parameters:
- PWM_DIV_RESET, 16'd0, reset value of the PWM prescaler divisor (reg1[15:0]).
- BLINK_DIV_RESET, 16'd0, reset value of the blink divisor (reg2[15:0]).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- led_in  in  4  LED pattern from the upstream PIO out_port; same clock domain, no synchroniser.
- address  in  2  Avalon-MM word address.
- chipselect  in  1  Avalon-MM select.
- write_n  in  1  Avalon-MM write strobe, active-low.
- writedata  in  32  Avalon-MM write data.
- readdata  out  32  Avalon-MM read data; combinational, 0 wait states.
- led_out  out  4  registered LED pin drive.

Behaviour:
- Reset is asynchronous and active-high; one clock.
- While reset is high, the following take these values:
  - duty = 32'hFFFF_FFFF
  - pwm_div = PWM_DIV_RESET
  - blink_div = BLINK_DIV_RESET
  - blink_en = 0
  - prescaler = 0, pwm_cnt = 0, blink_cnt = 0, phase = 0
  - led_out = 0
- Reset asserted mid-operation clears all of the above immediately, with no clock edge required.
- Register map (write when chipselect && !write_n):
  - addr0 duty: [8i+7:8i] is the duty for LED i.
  - addr1: [15:0] pwm_div; [31:16] ignored, read as 0.
  - addr2: [15:0] blink_div; [19:16] blink_en; other bits read as 0.
  - addr3 status, read-only, writes ignored: [3:0] led_out, [4] phase, [15:8] pwm_cnt, other bits 0.
- readdata decodes address regardless of chipselect.
- A write is visible on readdata in the cycle after the write edge.
- Prescaler:
  - 16-bit counter; tick = (prescaler == pwm_div).
  - On tick the prescaler returns to 0, otherwise it increments.
  - pwm_div = 0 gives a tick every cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick and wraps 255 -> 0.
  - wrap = tick && pwm_cnt == 255.
- PWM on condition per LED: pwm_on[i] = (pwm_cnt < duty[i]) || (duty[i] == 8'hFF).
  - duty 0 means always off.
  - duty FF means always on.
- Blink counter:
  - 16-bit blink_cnt advances on wrap.
  - On a wrap where blink_cnt == blink_div: phase toggles and blink_cnt returns to 0.
  - On any other wrap blink_cnt increments.
  - blink_div = 0 toggles phase on every wrap.
- Output: led_out[i] <= led_in[i] & pwm_on[i] & ~(blink_en[i] & phase).
  - Registered on every clk edge.
  - Latency is 1 cycle from led_in or counter state to led_out.
- Write to addr1 restarts the PWM timebase:
  - prescaler and pwm_cnt are cleared on that edge.
  - Any tick in the same cycle is discarded.
- Write to addr2 restarts the blink timebase:
  - blink_cnt and phase are cleared on that edge.
  - A wrap in the same cycle is discarded.
- A write to addr0 takes effect on the comparison from the next cycle; no counter is disturbed.
- Simultaneous tick and wrap follow the rules above; no other event ordering exists.

Test Plan:
- Reset, then hold led_in=4'b1010 with default registers -> led_out=4'b1010 exactly 1 cycle after led_in is applied; readdata at addr0=32'hFFFF_FFFF, addr3[3:0]=4'b1010.
- Write addr0=32'hFFFF_FF80, addr1=0, led_in=4'hF -> led_out[0] high for exactly 128 of every 256 cycles; led_out[3:1] constantly high.
- Write addr0=32'h0000_0000 with led_in=4'hF -> led_out stays 4'h0 for at least 1024 cycles.
- Write addr1=3 and addr0 byte0=8'h01 -> led_out[0] high for 4 cycles out of every 1024.
- Write addr2={blink_en=4'b0001, blink_div=1}, pwm_div=0, duty=FF -> led_out[0] alternates 512 cycles on / 512 cycles off; addr3[4] tracks phase; led_out[3:1] unaffected.
- During blinking, assert reset asynchronously between clock edges -> led_out=0 and phase=0 before the next edge; after release, registers read defaults and a write to addr3 leaves readdata unchanged.

Source files
------------

// File: rtl/led_pwm_blink_driver_if.sv
// rtl/led_pwm_blink_driver_if.sv - Avalon-MM register bus for the LED PWM/blink driver
// Ports (modports):
//   master : drives address, chipselect, write_n, writedata; samples readdata
//   slave  : samples address, chipselect, write_n, writedata; drives readdata
`timescale 1ns/1ps
interface led_pwm_blink_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_blink_driver.sv
// rtl/led_pwm_blink_driver.sv - per-LED 8-bit PWM brightness and blink gating behind the LED PIO
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-high reset
//   led_in  : 4-bit pattern from the upstream PIO out_port (same clock domain)
//   bus     : Avalon-MM slave, 0 wait states, combinational readdata
//             addr0 duty[31:0], addr1 pwm_div[15:0], addr2 {blink_en[19:16], blink_div[15:0]},
//             addr3 status {pwm_cnt[15:8], phase[4], led_out[3:0]} (read-only)
//   led_out : registered LED pin drive
`timescale 1ns/1ps
module led_pwm_blink_driver #(
  parameter logic [15:0] PWM_DIV_RESET   = 16'd0,
  parameter logic [15:0] BLINK_DIV_RESET = 16'd0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    led_in,
  led_pwm_blink_driver_if.slave         bus,
  output logic [3:0]                    led_out
);

  logic [31:0] duty_q,      duty_d;
  logic [15:0] pwm_div_q,   pwm_div_d;
  logic [15:0] blink_div_q, blink_div_d;
  logic [3:0]  blink_en_q,  blink_en_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic [7:0]  pwm_cnt_q,   pwm_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q,     phase_d;
  logic [3:0]  led_out_q,   led_out_d;

  logic        wr_en;
  logic        wr_duty;
  logic        wr_pwm;
  logic        wr_blink;
  logic        tick;
  logic        wrap;
  logic [3:0]  pwm_on;

  assign wr_en    = bus.chipselect && !bus.write_n;
  assign wr_duty  = wr_en && (bus.address == 2'd0);
  assign wr_pwm   = wr_en && (bus.address == 2'd1);
  assign wr_blink = wr_en && (bus.address == 2'd2);

  // A pwm_div write restarts the PWM timebase, so a tick (and hence a wrap)
  // coinciding with it must not advance anything.
  assign tick = (prescaler_q == pwm_div_q) && !wr_pwm;
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pwm_on[i] = (pwm_cnt_q < duty_q[8*i +: 8]) || (duty_q[8*i +: 8] == 8'hFF);
    end
  end

  always_comb begin
    duty_d      = duty_q;
    pwm_div_d   = pwm_div_q;
    blink_div_d = blink_div_q;
    blink_en_d  = blink_en_q;
    prescaler_d = prescaler_q;
    pwm_cnt_d   = pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    if (wr_duty) begin
      duty_d = bus.writedata;
    end
    if (wr_pwm) begin
      pwm_div_d = bus.writedata[15:0];
    end
    if (wr_blink) begin
      blink_div_d = bus.writedata[15:0];
      blink_en_d  = bus.writedata[19:16];
    end

    if (wr_pwm) begin
      prescaler_d = 16'd0;
      pwm_cnt_d   = 8'd0;
    end else if (tick) begin
      prescaler_d = 16'd0;
      pwm_cnt_d   = pwm_cnt_q + 8'd1;
    end else begin
      prescaler_d = prescaler_q + 16'd1;
    end

    if (wr_blink) begin
      blink_cnt_d = 16'd0;
      phase_d     = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == blink_div_q) begin
        blink_cnt_d = 16'd0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    led_out_d = led_in & pwm_on & ~(blink_en_q & {4{phase_q}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q      <= 32'hFFFF_FFFF;
      pwm_div_q   <= PWM_DIV_RESET;
      blink_div_q <= BLINK_DIV_RESET;
      blink_en_q  <= 4'd0;
      prescaler_q <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      blink_cnt_q <= 16'd0;
      phase_q     <= 1'b0;
      led_out_q   <= 4'd0;
    end else begin
      duty_q      <= duty_d;
      pwm_div_q   <= pwm_div_d;
      blink_div_q <= blink_div_d;
      blink_en_q  <= blink_en_d;
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_out_q   <= led_out_d;
    end
  end

  assign led_out = led_out_q;

  // Read decode ignores chipselect so the register file is always observable.
  always_comb begin
    case (bus.address)
      2'd0:    bus.readdata = duty_q;
      2'd1:    bus.readdata = {16'd0, pwm_div_q};
      2'd2:    bus.readdata = {12'd0, blink_en_q, blink_div_q};
      default: bus.readdata = {16'd0, pwm_cnt_q, 3'd0, phase_q, led_out_q};
    endcase
  end

endmodule
